mem_access_controller: RTL and testbench
========================================

Name: mem_access_controller

Overview:
Initiator side of the data-memory interface: accepts one load/store request at a time from the MEM pipeline stage over a valid/ready handshake. Drives the data memory's read-enable, write-enable, address and write-data signals. Returns load data, or a store acknowledge, over a valid/ready response channel. Asserts a stall toward the pipeline while a request is in flight, and blocks out-of-range accesses.

Parameters:
ADDR_WIDTH, 16, width of word address
DATA_WIDTH, 16, width of data word
MEM_DEPTH, 256, number of implemented words; addresses >= MEM_DEPTH are errors
READ_LATENCY, 1, cycles MemRead/address held before read data is sampled (legal range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
i_Req_Valid  input  1  request present
o_Req_Ready  output  1  controller can accept request
i_Req_Write  input  1  1 = store, 0 = load
i_Req_Address  input  ADDR_WIDTH  word address
i_Req_Write_Data  input  DATA_WIDTH  store data
o_Resp_Valid  output  1  response present
i_Resp_Ready  input  1  consumer accepts response
o_Resp_Read_Data  output  DATA_WIDTH  load data (0 for stores and errors)
o_Resp_Write  output  1  response belongs to a store
o_Resp_Error  output  1  address out of range, no memory access made
o_Stall  output  1  request in flight (state != IDLE)
o_Sig_MemRead  output  1  memory read enable
o_Sig_MemWrite  output  1  memory write enable
o_Mem_Address  output  ADDR_WIDTH  memory address
o_Mem_Write_Data  output  DATA_WIDTH  memory write data
i_Mem_Read_Data  input  DATA_WIDTH  memory read data

Behaviour:
- One clock (clk); reset is synchronous, active-high (rst).
- Reset:
  - state = IDLE; all registered outputs = 0 (Resp_*, MemRead, MemWrite, Mem_Address, Mem_Write_Data).
  - o_Req_Ready = 0 while rst = 1.
  - Reset mid-operation aborts immediately; a pending response is lost.
- o_Req_Ready = (state == IDLE) && !rst, combinational. o_Stall = (state != IDLE).
- Accept: i_Req_Valid && o_Req_Ready at edge T captures write flag, address and data. At most one request is in flight.
- State machine:
  - IDLE -> ERR on accept with address >= MEM_DEPTH.
  - IDLE -> WRITE on accept of an in-range store.
  - IDLE -> READ on accept of an in-range load; the counter loads READ_LATENCY-1.
  - WRITE: cycle T+1, o_Sig_MemWrite = 1 for exactly one cycle, with address and data stable. Then -> RESP with Resp_Write = 1 and Read_Data = 0.
  - READ: cycles T+1 .. T+READ_LATENCY, o_Sig_MemRead = 1 and address stable. The counter decrements each cycle.
    - When the counter reaches 0, i_Mem_Read_Data is sampled into o_Resp_Read_Data -> RESP.
  - ERR: no memory enable is asserted. -> RESP with Resp_Error = 1 and Read_Data = 0, one cycle after accept.
  - RESP: o_Resp_Valid = 1 and all Resp_* outputs held stable until i_Resp_Ready = 1. On handshake, -> IDLE; Resp_Valid and flags clear next cycle.
- Latency from accept to Resp_Valid (no backpressure):
  - store: 2 cycles
  - load: READ_LATENCY+1 cycles
  - error: 1 cycle
- Next accept no earlier than the cycle after the response handshake; there is no same-cycle overlap.
- MemRead and MemWrite are never both 1. Neither is asserted outside READ/WRITE.
- o_Mem_Address and o_Mem_Write_Data retain their last value while idle.
- i_Req_Valid while not ready is ignored; the requester must hold the request.
- An i_Resp_Ready level outside RESP has no effect.
- Address compare is unsigned over the full ADDR_WIDTH. MEM_DEPTH = 2^ADDR_WIDTH disables errors.

Decomposition:
- Shared package mem_if_pkg:
  - state encoding (IDLE, READ, WRITE, RESP, ERR)
  - default ADDR_WIDTH/DATA_WIDTH constants, also used by data_memory
- One natural sub-module: mem_latency_counter, a loadable 4-bit down-counter with zero flag.
- All other logic stays in one FSM module.

Test Plan:
- Store addr 0x0010 data 0xBEEF, Resp_Ready = 1 -> MemWrite high exactly 1 cycle at T+1 with Mem_Address 0x0010 and Write_Data 0xBEEF; Resp_Valid at T+2 with Resp_Write = 1, Error = 0; MemRead never high.
- Load addr 0x0010, READ_LATENCY = 3, memory returns 0xBEEF -> MemRead high T+1..T+3; Resp_Valid at T+4 with Read_Data 0xBEEF; o_Stall high T+1..T+4.
- Load addr 0x0100 with MEM_DEPTH = 256 -> no MemRead/MemWrite; Resp_Valid at T+1 with Resp_Error = 1, Read_Data 0x0000.
- Backpressure: Resp_Ready = 0 for 5 cycles after Resp_Valid -> Resp_* stable and Req_Ready = 0 throughout; a new request is accepted only the cycle after the handshake.
- Back-to-back store then load to the same address 0x0005 (0x1234) -> load returns 0x1234.
- rst asserted during READ cycle 2 -> next cycle all outputs 0, state IDLE; Req_Ready = 1 after rst deasserts; no Resp_Valid from the aborted load.

Source files
------------

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared definitions for the data-memory interface
//
// Purpose : state encoding for mem_access_controller and the default
//           address/data widths shared with data_memory.
// Ports   : none (package).

package mem_if_pkg;

   localparam int MEM_ADDR_WIDTH = 16;
   localparam int MEM_DATA_WIDTH = 16;
   localparam int LAT_CNT_WIDTH  = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      RESP  = 3'd3,
      ERR   = 3'd4
   } mem_state_t;

endpackage

// File: rtl/mem_latency_counter.sv
// rtl/mem_latency_counter.sv - loadable 4-bit down-counter with zero flag
//
// Purpose : counts the remaining read-latency cycles of a load.
// Ports   : clk, rst (sync, active-high)
//           load       - load load_value (has priority over decrement)
//           load_value - value to load
//           decrement  - count down by one, saturating at zero
//           zero       - count == 0

module mem_latency_counter
   import mem_if_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [LAT_CNT_WIDTH-1:0] load_value,
   input  logic                     decrement,
   output logic                     zero
);

   logic [LAT_CNT_WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (decrement && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_access_controller.sv
// rtl/mem_access_controller.sv - load/store initiator for the data memory
//
// Purpose : accepts one load/store from the MEM stage, drives the data
//           memory enables/address/data, returns load data or a store
//           acknowledge, stalls the pipeline while busy and rejects
//           out-of-range addresses without touching memory.
// Ports   : clk, rst (sync, active-high)
//           i_Req_*   - request channel (valid/ready, write flag, addr, data)
//           i_Resp_Ready, o_Resp_* - response channel
//           o_Stall   - request in flight
//           o_Sig_MemRead/o_Sig_MemWrite, o_Mem_Address, o_Mem_Write_Data,
//           i_Mem_Read_Data - data memory side

module mem_access_controller
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = MEM_DATA_WIDTH,
   parameter int MEM_DEPTH    = 256,
   parameter int READ_LATENCY = 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_Req_Valid,
   output logic                  o_Req_Ready,
   input  logic                  i_Req_Write,
   input  logic [ADDR_WIDTH-1:0] i_Req_Address,
   input  logic [DATA_WIDTH-1:0] i_Req_Write_Data,
   output logic                  o_Resp_Valid,
   input  logic                  i_Resp_Ready,
   output logic [DATA_WIDTH-1:0] o_Resp_Read_Data,
   output logic                  o_Resp_Write,
   output logic                  o_Resp_Error,
   output logic                  o_Stall,
   output logic                  o_Sig_MemRead,
   output logic                  o_Sig_MemWrite,
   output logic [ADDR_WIDTH-1:0] o_Mem_Address,
   output logic [DATA_WIDTH-1:0] o_Mem_Write_Data,
   input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data
);

   // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable and
   // makes every address in range.
   localparam logic [ADDR_WIDTH:0]          DEPTH_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);
   localparam logic [LAT_CNT_WIDTH-1:0]     LAT_RELOAD  = LAT_CNT_WIDTH'(READ_LATENCY - 1);

   mem_state_t state, state_next;

   logic                  resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
   logic                  resp_write_q, resp_write_d;
   logic                  resp_error_q, resp_error_d;
   logic                  mem_read_q,   mem_read_d;
   logic                  mem_write_q,  mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;

   logic req_ready;
   logic accept;
   logic addr_error;
   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;

   assign req_ready  = (state == IDLE) && !rst;
   assign accept     = i_Req_Valid && req_ready;
   assign addr_error = ({1'b0, i_Req_Address} >= DEPTH_LIMIT);

   mem_latency_counter u_lat_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (LAT_RELOAD),
      .decrement  (cnt_dec),
      .zero       (cnt_zero)
   );

   always_comb begin
      state_next   = state;
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_write_d = resp_write_q;
      resp_error_d = resp_error_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               mem_addr_d  = i_Req_Address;
               mem_wdata_d = i_Req_Write_Data;
               if (addr_error) begin
                  // Error response is presented straight away: no memory cycle.
                  state_next   = ERR;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_write_d = i_Req_Write;
                  resp_data_d  = '0;
               end else if (i_Req_Write) begin
                  state_next  = WRITE;
                  mem_write_d = 1'b1;
               end else begin
                  state_next = READ;
                  mem_read_d = 1'b1;
                  cnt_load   = 1'b1;
               end
            end
         end
         WRITE: begin
            state_next   = RESP;
            mem_write_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_write_d = 1'b1;
            resp_error_d = 1'b0;
            resp_data_d  = '0;
         end
         READ: begin
            if (cnt_zero) begin
               state_next   = RESP;
               mem_read_d   = 1'b0;
               resp_valid_d = 1'b1;
               resp_write_d = 1'b0;
               resp_error_d = 1'b0;
               resp_data_d  = i_Mem_Read_Data;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ERR, RESP: begin
            if (i_Resp_Ready) begin
               state_next   = IDLE;
               resp_valid_d = 1'b0;
               resp_write_d = 1'b0;
               resp_error_d = 1'b0;
               resp_data_d  = '0;
            end else if (state == ERR) begin
               // Unconsumed error response is held like any other response.
               state_next = RESP;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_write_q <= 1'b0;
         resp_error_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state        <= state_next;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_write_q <= resp_write_d;
         resp_error_q <= resp_error_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign o_Req_Ready      = req_ready;
   assign o_Stall          = (state != IDLE);
   assign o_Resp_Valid     = resp_valid_q;
   assign o_Resp_Read_Data = resp_data_q;
   assign o_Resp_Write     = resp_write_q;
   assign o_Resp_Error     = resp_error_q;
   assign o_Sig_MemRead    = mem_read_q;
   assign o_Sig_MemWrite   = mem_write_q;
   assign o_Mem_Address    = mem_addr_q;
   assign o_Mem_Write_Data = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// tb/tb_mem_access_controller.sv - directed self-checking bench for mem_access_controller

module tb_mem_access_controller;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [15:0] req_address;
   logic [15:0] req_write_data;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_read_data;
   logic        resp_write;
   logic        resp_error;
   logic        stall;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_write_data;
   logic [15:0] mem_read_data;

   logic [15:0] tb_mem [0:255];

   int n_cmp = 0;
   int n_err = 0;

   mem_access_controller #(
      .ADDR_WIDTH   (16),
      .DATA_WIDTH   (16),
      .MEM_DEPTH    (256),
      .READ_LATENCY (3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_Req_Valid      (req_valid),
      .o_Req_Ready      (req_ready),
      .i_Req_Write      (req_write),
      .i_Req_Address    (req_address),
      .i_Req_Write_Data (req_write_data),
      .o_Resp_Valid     (resp_valid),
      .i_Resp_Ready     (resp_ready),
      .o_Resp_Read_Data (resp_read_data),
      .o_Resp_Write     (resp_write),
      .o_Resp_Error     (resp_error),
      .o_Stall          (stall),
      .o_Sig_MemRead    (mem_read),
      .o_Sig_MemWrite   (mem_write),
      .o_Mem_Address    (mem_address),
      .o_Mem_Write_Data (mem_write_data),
      .i_Mem_Read_Data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple data memory: synchronous write, combinational read.
   always @(posedge clk) begin
      if (mem_write) tb_mem[mem_address[7:0]] <= mem_write_data;
   end
   assign mem_read_data = mem_read ? tb_mem[mem_address[7:0]] : 16'h0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " resp_valid"}, resp_valid, 0);
      chk({tag, " mem_read"},   mem_read,   0);
      chk({tag, " mem_write"},  mem_write,  0);
      chk({tag, " stall"},      stall,      0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tb_mem[i] = 16'h0000;
      rst            = 1'b1;
      req_valid      = 1'b0;
      req_write      = 1'b0;
      req_address    = 16'h0000;
      req_write_data = 16'h0000;
      resp_ready     = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst req_ready", req_ready, 0);
      chk_idle_outputs("rst");
      chk("rst mem_address", mem_address, 16'h0000);
      chk("rst resp_data", resp_read_data, 16'h0000);
      rst = 1'b0;
      #1;
      chk("post-rst req_ready", req_ready, 1);

      // Store 0x0010 <- 0xBEEF
      req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0010; req_write_data = 16'hBEEF;
      tick();
      req_valid = 1'b0;
      chk("st T+1 mem_write", mem_write, 1);
      chk("st T+1 mem_read", mem_read, 0);
      chk("st T+1 mem_address", mem_address, 16'h0010);
      chk("st T+1 mem_wdata", mem_write_data, 16'hBEEF);
      chk("st T+1 stall", stall, 1);
      chk("st T+1 req_ready", req_ready, 0);
      chk("st T+1 resp_valid", resp_valid, 0);
      tick();
      chk("st T+2 mem_write", mem_write, 0);
      chk("st T+2 mem_read", mem_read, 0);
      chk("st T+2 resp_valid", resp_valid, 1);
      chk("st T+2 resp_write", resp_write, 1);
      chk("st T+2 resp_error", resp_error, 0);
      chk("st T+2 resp_data", resp_read_data, 16'h0000);
      tick();
      chk_idle_outputs("st T+3");
      chk("st T+3 req_ready", req_ready, 1);
      chk("st T+3 addr held", mem_address, 16'h0010);

      // Load 0x0010, READ_LATENCY = 3
      req_valid = 1'b1; req_write = 1'b0; req_address = 16'h0010;
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("ld T+%0d mem_read", c), mem_read, 1);
         chk($sformatf("ld T+%0d mem_write", c), mem_write, 0);
         chk($sformatf("ld T+%0d stall", c), stall, 1);
         chk($sformatf("ld T+%0d resp_valid", c), resp_valid, 0);
         tick();
      end
      chk("ld T+4 resp_valid", resp_valid, 1);
      chk("ld T+4 resp_data", resp_read_data, 16'hBEEF);
      chk("ld T+4 resp_write", resp_write, 0);
      chk("ld T+4 resp_error", resp_error, 0);
      chk("ld T+4 mem_read", mem_read, 0);
      chk("ld T+4 stall", stall, 1);
      tick();
      chk_idle_outputs("ld T+5");

      // Out-of-range load 0x0100
      req_valid = 1'b1; req_write = 1'b0; req_address = 16'h0100;
      tick();
      req_valid = 1'b0;
      chk("err T+1 resp_valid", resp_valid, 1);
      chk("err T+1 resp_error", resp_error, 1);
      chk("err T+1 resp_data", resp_read_data, 16'h0000);
      chk("err T+1 mem_read", mem_read, 0);
      chk("err T+1 mem_write", mem_write, 0);
      chk("err T+1 stall", stall, 1);
      tick();
      chk_idle_outputs("err T+2");

      // Out-of-range store 0xFFFF
      req_valid = 1'b1; req_write = 1'b1; req_address = 16'hFFFF; req_write_data = 16'h5555;
      tick();
      req_valid = 1'b0;
      chk("errst mem_write", mem_write, 0);
      chk("errst resp_error", resp_error, 1);
      chk("errst resp_write", resp_write, 1);
      tick();

      // Last in-range address 0x00FF loads normally
      req_valid = 1'b1; req_write = 1'b0; req_address = 16'h00FF;
      tick();
      req_valid = 1'b0;
      chk("edge mem_read", mem_read, 1);
      tick(); tick(); tick();
      chk("edge resp_valid", resp_valid, 1);
      chk("edge resp_error", resp_error, 0);
      chk("edge resp_data", resp_read_data, 16'h0000);
      tick();

      // Store 0x0005 <- 0x1234 under response backpressure, load held pending
      resp_ready = 1'b0;
      req_valid = 1'b1; req_write = 1'b1; req_address = 16'h0005; req_write_data = 16'h1234;
      tick();
      req_write = 1'b0;
      chk("bp mem_write", mem_write, 1);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("bp%0d resp_valid", c), resp_valid, 1);
         chk($sformatf("bp%0d resp_write", c), resp_write, 1);
         chk($sformatf("bp%0d resp_error", c), resp_error, 0);
         chk($sformatf("bp%0d resp_data", c), resp_read_data, 16'h0000);
         chk($sformatf("bp%0d req_ready", c), req_ready, 0);
         chk($sformatf("bp%0d mem_read", c), mem_read, 0);
         tick();
      end
      resp_ready = 1'b1;
      #1;
      chk("bp hs req_ready", req_ready, 0);
      tick();
      chk("bp post-hs resp_valid", resp_valid, 0);
      chk("bp post-hs req_ready", req_ready, 1);
      chk("bp post-hs mem_read", mem_read, 0);
      tick();
      req_valid = 1'b0;
      chk("b2b ld accepted", mem_read, 1);
      chk("b2b ld address", mem_address, 16'h0005);
      tick(); tick(); tick();
      chk("b2b resp_valid", resp_valid, 1);
      chk("b2b resp_data", resp_read_data, 16'h1234);
      tick();

      // Reset during READ cycle 2
      req_valid = 1'b1; req_write = 1'b0; req_address = 16'h0010;
      tick();
      req_valid = 1'b0;
      chk("abort T+1 mem_read", mem_read, 1);
      tick();
      chk("abort T+2 mem_read", mem_read, 1);
      rst = 1'b1;
      tick();
      chk_idle_outputs("abort rst");
      chk("abort req_ready", req_ready, 0);
      chk("abort mem_address", mem_address, 16'h0000);
      chk("abort resp_data", resp_read_data, 16'h0000);
      rst = 1'b0;
      #1;
      chk("abort post req_ready", req_ready, 1);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("abort quiet%0d resp_valid", c), resp_valid, 0);
         chk($sformatf("abort quiet%0d stall", c), stall, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
